// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider FSM states, binary32 constants,
// exception-flag bit positions and field-extract helpers.
package fpu_pkg;

  // Quotient bits produced per divide: 1 integer + 23 fraction + guard + round.
  localparam int ITERS = 26;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int          FP_BIAS = 127;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ROUND,
    S_DONE
  } div_state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_frac(x) != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_frac(x) == 23'd0);
  endfunction

  // Subnormals are flushed, so any zero exponent counts as zero.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return fp_exp(x) == 8'h00;
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even for a normalised quotient, followed by the
// overflow/underflow range check on the biased exponent.
// With FPU_DIV_FLAGS_EN defined an inexact output is also provided.
module fpu_round_rne (
  input  logic [22:0]       frac,
  input  logic              guard,
  input  logic              rnd,
  input  logic              sticky,
  input  logic signed [9:0] exp_in,
  output logic [22:0]       frac_out,
  output logic [7:0]        exp_out,
  output logic              of,
  output logic              uf
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic              nx
`endif
);

  logic              round_up;
  logic              carry;
  logic signed [9:0] exp_adj;

  // Guard is the half-ulp bit; ties go to the even fraction.
  assign round_up = guard & (rnd | sticky | frac[0]);

  // A carry out of the fraction means 1.111..1 rounded to 10.000..0:
  // the fraction wraps to zero and the exponent absorbs the carry.
  assign {carry, frac_out} = {1'b0, frac} + 24'(round_up);
  assign exp_adj           = exp_in + 10'(carry);
  assign exp_out           = exp_adj[7:0];

  assign of = exp_adj >= 10'sd255;
  assign uf = exp_adj <= 10'sd0;

`ifdef FPU_DIV_FLAGS_EN
  assign nx = guard | rnd | sticky;
`endif

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential binary32 divider: radix-2 restoring division, one quotient
// bit per cycle, round-to-nearest-even, subnormals flushed to zero.
// Define FPU_DIV_FLAGS_EN to add the registered fflags output.
module fpu_div_seq
  import fpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              sign;
  logic signed [9:0] exp_q;
  logic [24:0]       rem;
  logic [23:0]       divisor;
  // The leading 1 of the quotient shifts out on the last iteration, so
  // 25 bits hold exactly {fraction[22:0], guard, round}.
  logic [24:0]       quo;

  // Operand decode, evaluated while IDLE.
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              sign_in;
  logic [23:0]       ma, mb;
  logic              a_lt_b;
  logic signed [9:0] exp_raw, exp_init;
  logic [24:0]       rem_init;

  assign a_nan   = fp_is_nan(op_a);
  assign b_nan   = fp_is_nan(op_b);
  assign a_inf   = fp_is_inf(op_a);
  assign b_inf   = fp_is_inf(op_b);
  assign a_zero  = fp_is_zero(op_a);
  assign b_zero  = fp_is_zero(op_b);
  assign sign_in = fp_sign(op_a) ^ fp_sign(op_b);

  assign ma       = {1'b1, fp_frac(op_a)};
  assign mb       = {1'b1, fp_frac(op_b)};
  assign a_lt_b   = ma < mb;
  assign exp_raw  = $signed({2'b00, fp_exp(op_a)}) - $signed({2'b00, fp_exp(op_b)})
                    + 10'(FP_BIAS);
  // Pre-shifting a smaller dividend guarantees the quotient MSB is 1.
  assign exp_init = exp_raw - $signed({9'd0, a_lt_b});
  assign rem_init = a_lt_b ? {ma, 1'b0} : {1'b0, ma};

  // Special-case result, first matching rule wins.
  logic        spec_hit;
  logic [31:0] spec_result;

  // Classify operands into the special-case table or the iterative path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    spec_hit    = 1'b1;
    spec_result = FP_QNAN;
    if (a_nan || b_nan) begin
      spec_result = FP_QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = FP_QNAN;
    end else if (a_inf) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_result = {sign_in, 31'd0};
    end else if (b_zero) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero) begin
      spec_result = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

`ifdef FPU_DIV_FLAGS_EN
  logic       spec_nv, spec_dz;
  logic [4:0] spec_flags;
  assign spec_nv = !(a_nan || b_nan) && ((a_zero && b_zero) || (a_inf && b_inf));
  assign spec_dz = !(a_nan || b_nan) && !spec_nv && !a_inf && !b_inf && b_zero;
  always_comb begin
    spec_flags          = 5'd0;
    spec_flags[FLAG_NV] = spec_nv;
    spec_flags[FLAG_DZ] = spec_dz;
  end
`endif

  // One restoring-division step.
  logic        rem_ge;
  logic [24:0] rem_diff, rem_next;
  assign rem_ge   = rem >= {1'b0, divisor};
  assign rem_diff = rem_ge ? rem - {1'b0, divisor} : rem;
  assign rem_next = rem_diff << 1;

  // Rounding and range check on the finished quotient.
  logic [22:0] rnd_frac;
  logic [7:0]  rnd_exp;
  logic        rnd_of, rnd_uf;
  logic [31:0] norm_result;
`ifdef FPU_DIV_FLAGS_EN
  logic        rnd_nx;
  logic [4:0]  norm_flags;
`endif

  fpu_round_rne u_round (
    .frac     (quo[24:2]),
    .guard    (quo[1]),
    .rnd      (quo[0]),
    .sticky   (rem != 25'd0),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .of       (rnd_of),
    .uf       (rnd_uf)
`ifdef FPU_DIV_FLAGS_EN
    ,
    .nx       (rnd_nx)
`endif
  );

  // Saturate to signed inf / signed zero when the exponent leaves range.
  always_comb begin
    if (rnd_of)      norm_result = {sign, 8'hFF, 23'd0};
    else if (rnd_uf) norm_result = {sign, 31'd0};
    else             norm_result = {sign, rnd_exp, rnd_frac};
  end

`ifdef FPU_DIV_FLAGS_EN
  always_comb begin
    norm_flags          = 5'd0;
    norm_flags[FLAG_OF] = rnd_of;
    norm_flags[FLAG_UF] = rnd_uf;
    norm_flags[FLAG_NX] = rnd_nx | rnd_of | rnd_uf;
  end
`endif

  // Control FSM with registered busy/done/result and the divide datapath.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      sign    <= 1'b0;
      exp_q   <= 10'sd0;
      rem     <= 25'd0;
      divisor <= 24'd0;
      quo     <= 25'd0;
`ifdef FPU_DIV_FLAGS_EN
      fflags  <= 5'd0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (spec_hit) begin
              result <= spec_result;
`ifdef FPU_DIV_FLAGS_EN
              fflags <= spec_flags;
`endif
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              sign    <= sign_in;
              exp_q   <= exp_init;
              rem     <= rem_init;
              divisor <= mb;
              quo     <= 25'd0;
              cnt     <= '0;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo <= {quo[23:0], rem_ge};
          rem <= rem_next;
          if (cnt == CNT_W'(ITERS - 1)) begin
            cnt   <= '0;
            state <= S_ROUND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ROUND: begin
          result <= norm_result;
`ifdef FPU_DIV_FLAGS_EN
          fflags <= norm_flags;
`endif
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// Self-checking bench for fpu_div_seq: a vector table driven through a
// scoreboard queue, plus hand-written busy-start, DONE-start and abort cases.
module tb_fpu_div_seq;
  import fpu_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a  = 32'd0;
  logic [31:0] op_b  = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef FPU_DIV_FLAGS_EN
  logic [4:0]  fflags;
`endif

  fpu_div_seq dut (
    .CLK    (clk),
    .RST    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef FPU_DIV_FLAGS_EN
    ,
    .fflags (fflags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one divide at the next falling edge, then follow it cycle by
  // cycle. lat counts falling edges after the accept edge, so done seen at
  // lat == 28 is T+28. Operands are scrambled after accept to prove they
  // were latched. inject_at re-asserts start mid-run; abort_at pulls reset.
  task automatic do_op(input vec_t v, input int inject_at, input int abort_at);
    int   lat;
    vec_t e;
    lat = 0;
    @(negedge clk);
    op_a  = v.a;
    op_b  = v.b;
    start = 1'b1;
    if (abort_at == 0) sb.push_back(v);
    do begin
      @(negedge clk);
      lat++;
      start = (lat == inject_at);
      op_a  = $urandom;
      op_b  = $urandom;
      if (lat == 1) check({v.name, " busy_rise"}, 32'(busy), 32'd1);
      if (lat == abort_at) begin
        rst = 1'b0;
        #1;
        check({v.name, " abort_busy"}, 32'(busy), 32'd0);
        check({v.name, " abort_done"}, 32'(done), 32'd0);
        check({v.name, " abort_result"}, result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end while (!done && lat < 100);
    check({v.name, " done_seen"}, 32'(done), 32'd1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, " result"}, result, e.res);
      check({e.name, " latency"}, 32'(lat), 32'(e.lat));
      check({e.name, " busy_with_done"}, 32'(busy), 32'd1);
`ifdef FPU_DIV_FLAGS_EN
      check({e.name, " fflags"}, 32'(fflags), 32'(e.flg));
`endif
    end else begin
      sb.delete();
    end
  endtask

  // Normal transaction plus the one-cycle done pulse / busy fall check.
  task automatic run_vec(input vec_t v);
    do_op(v, 0, 0);
    @(negedge clk);
    check({v.name, " done_pulse"}, 32'(done), 32'd0);
    check({v.name, " busy_fall"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[$];
  vec_t six_by_two;

  initial begin
    int seen;
    int busy_rises;
    logic prev_busy;

    six_by_two = '{"6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28};
    vecs.push_back(six_by_two);
    vecs.push_back('{"1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28});
    vecs.push_back('{"2/3",        32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'h01, 28});
    vecs.push_back('{"-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 28});
    vecs.push_back('{"1/1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 5'h00, 28});
    vecs.push_back('{"max/min",    32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'h05, 28});
    vecs.push_back('{"min/max",    32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'h03, 28});
    vecs.push_back('{"1/0",        32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08,  1});
    vecs.push_back('{"-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 5'h08,  1});
    vecs.push_back('{"1/denorm",   32'h3F800000, 32'h00000001, 32'h7F800000, 5'h08,  1});
    vecs.push_back('{"0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10,  1});
    vecs.push_back('{"inf/-inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10,  1});
    vecs.push_back('{"nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'h00,  1});
    vecs.push_back('{"-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00,  1});
    vecs.push_back('{"1/-inf",     32'h3F800000, 32'hFF800000, 32'h80000000, 5'h00,  1});
    vecs.push_back('{"-0/5",       32'h80000000, 32'h40A00000, 32'h80000000, 5'h00,  1});
    vecs.push_back('{"denorm/1",   32'h00000001, 32'h3F800000, 32'h00000000, 5'h00,  1});

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
`ifdef FPU_DIV_FLAGS_EN
    check("reset fflags", 32'(fflags), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start pulsed at cycle 10 of a running divide is ignored.
    do_op(six_by_two, 10, 0);
    @(negedge clk);
    check("busy_start busy_fall", 32'(busy), 32'd0);
    busy_rises = 0;
    prev_busy  = busy;
    repeat (35) begin
      @(negedge clk);
      if (busy && !prev_busy) busy_rises++;
      if (done) busy_rises++;
      prev_busy = busy;
    end
    check("busy_start no_second_run", 32'(busy_rises), 32'd0);
    check("busy_start result_held", result, 32'h40400000);

    // start asserted in the DONE cycle is ignored.
    do_op(six_by_two, 0, 0);
    start = 1'b1;
    op_a  = 32'h3F800000;
    op_b  = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    check("done_start ignored_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (32) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("done_start ignored_done", 32'(seen), 32'd0);
    // Earliest next accept works normally.
    run_vec('{"after_done 1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28});

    // Reset at cycle 12 aborts without a done; a fresh divide then completes.
    do_op(six_by_two, 0, 12);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no_done", 32'(seen), 32'd0);
    check("abort result_zero", result, 32'd0);
    run_vec('{"post_abort 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 28});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
